// File: rtl/seg_p2s_pkg.sv
// Shared types and helpers for the segment-chain parallel-to-serial shifter.
package seg_p2s_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } state_t;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/seg_p2s_tick_gen.sv
// Half-period divider: pulses phase_end on the last system cycle of each serial-clock phase.
module p2s_tick_gen
  import seg_p2s_pkg::*;
#(
  parameter int DIV_HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic phase_end
);

  localparam int CW = cnt_width(DIV_HALF);
  localparam logic [CW-1:0] LAST = CW'(DIV_HALF - 1);

  logic [CW-1:0] cnt;

  assign phase_end = !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || phase_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_p2s_shifter.sv
// Serialises a captured display word onto a 74HC164/595-style chain: data, clock, then latch.
module seg_p2s_shifter
  import seg_p2s_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int DIV_HALF  = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] par_data,
  output logic              s_clk,
  output logic              s_data,
  output logic              s_latch,
  output logic              busy,
  output logic              done
);

  localparam int BW = cnt_width(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state, state_next;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_shifted;
  logic [BW-1:0]     bit_cnt;
  logic              head;
  logic              phase_end;
  logic              tick_clr;
  logic              s_clk_next, s_data_next, s_latch_next, busy_next, done_next;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign head          = shreg[DATA_W-1];
      assign shreg_shifted = {shreg[DATA_W-2:0], 1'b0};
    end else begin : g_lsb
      assign head          = shreg[0];
      assign shreg_shifted = {1'b0, shreg[DATA_W-1:1]};
    end
  endgenerate

  p2s_tick_gen #(
    .DIV_HALF (DIV_HALF)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (tick_clr),
    .phase_end (phase_end)
  );

  always_comb begin
    state_next   = state;
    tick_clr     = 1'b0;
    s_clk_next   = 1'b0;
    s_data_next  = s_data;
    s_latch_next = 1'b0;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        tick_clr = 1'b1;
        if (start) state_next = SHIFT_LO;
      end
      SHIFT_LO: begin
        s_data_next = head;
        busy_next   = 1'b1;
        if (phase_end) state_next = SHIFT_HI;
      end
      SHIFT_HI: begin
        s_clk_next = 1'b1;
        busy_next  = 1'b1;
        if (phase_end) state_next = (bit_cnt == LAST_BIT) ? LATCH : SHIFT_LO;
      end
      LATCH: begin
        s_latch_next = 1'b1;
        busy_next    = 1'b1;
        if (phase_end) state_next = DONE;
      end
      DONE: begin
        tick_clr   = 1'b1;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        tick_clr   = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are registered copies of the state decode, so they trail the state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      s_clk   <= 1'b0;
      s_data  <= 1'b0;
      s_latch <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      s_clk   <= s_clk_next;
      s_data  <= s_data_next;
      s_latch <= s_latch_next;
      busy    <= busy_next;
      done    <= done_next;
      if (state == IDLE && start) begin
        shreg   <= par_data;
        bit_cnt <= '0;
      end else if (state == SHIFT_HI && phase_end) begin
        shreg   <= shreg_shifted;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/seg_p2s_shifter.md
Name: seg_p2s_shifter

Overview:
- Downstream consumer of the 64-bit display-data 2:1 select stage.
- Captures the selected 64-bit segment/LED word and serialises it onto the board's shift-register chain: serial clock, serial data, then a latch strobe.
- Sits between the display-data mux and the on-board 74HC164/595-style segment shift registers.
- A start/done handshake lets the display controller refresh the chain whenever the selected word changes.

Parameters:
- DATA_W, 64: serial word width; minimum 2.
- DIV_HALF, 2: system-clock cycles per serial-clock half period; minimum 1.
- MSB_FIRST, 1: 1 = bit DATA_W-1 shifted first; 0 = bit 0 shifted first.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to send par_data; single-cycle or level.
- par_data  in  DATA_W  word from the upstream 64-bit mux; sampled only on an accepted start.
- s_clk  out  1  serial shift clock to the register chain.
- s_data  out  1  serial data; stable for the whole high phase of s_clk.
- s_latch  out  1  parallel-load strobe to the chain; active high.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at end of transfer.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n); on assertion all outputs go to 0 immediately (s_clk, s_data, s_latch, busy, done), the FSM goes to IDLE, the shift register and counters clear.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- IDLE: start=1 captures par_data into an internal shift register on that edge. Next state is SHIFT_LO and busy=1 from the next cycle.
- start is ignored in every state except IDLE; no queueing of requests.
- SHIFT_LO: s_clk=0. s_data = current head bit, driven on entry. Lasts DIV_HALF cycles, then goes to SHIFT_HI.
- SHIFT_HI: s_clk=1 for DIV_HALF cycles; the chain samples s_data on the s_clk rising edge. On exit the register advances one bit and the bit counter increments.
- SHIFT_HI exit: if DATA_W bits have been sent, go to LATCH; otherwise go to SHIFT_LO.
- LATCH: s_clk=0, s_latch=1 for DIV_HALF cycles, then DONE.
- DONE: exactly one cycle. done=1, busy=0, s_latch=0, then IDLE.
- A start in the DONE cycle is ignored. A start in the first IDLE cycle after DONE is accepted, so back-to-back transfers have one dead cycle.
- Latency from an accepted start edge to the done pulse = 2*DIV_HALF*DATA_W + DIV_HALF + 1 cycles, i.e. 259 at defaults.
- s_data holds the last shifted bit through LATCH and DONE, and stays there in IDLE until the next transfer.
- par_data changes during a transfer have no effect on the current transfer.
- Bit counter width is clog2(DATA_W+1); the divider counter width is clog2(DIV_HALF+1).
- An rst_n assertion mid-transfer aborts immediately with no latch pulse. After release the block sits in IDLE; no partial resume.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package seg_p2s_pkg: state enum (IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE) and a localparam function for counter widths.
- Sub-module p2s_tick_gen: DIV_HALF half-period counter with clear input, producing a one-cycle phase_end pulse.
- The FSM and shift register stay in the top module.

Test Plan:
- Reset, then defaults, par_data=64'h8000_0000_0000_0001, start pulse -> 64 s_clk rising edges. s_data is 1 on the first and last edges and 0 on all others. s_latch is high 2 cycles. done pulses exactly 259 cycles after the start edge. busy is low only in the DONE cycle and after.
- MSB_FIRST=0, par_data=64'h0000_0000_0000_00A5 -> the first 8 sampled bits are 1,0,1,0,0,1,0,1, then 56 zeros.
- start held high continuously with par_data=all ones -> transfers repeat with exactly one idle cycle between done and the next busy rise. Starts during busy are never double-counted.
- Change par_data to 0 midway through a transfer of all ones -> all 64 sampled bits are still 1.
- Assert rst_n low at bit 30 -> all outputs are 0 within the same cycle and s_latch never pulses. After release, a new start with par_data=64'h0123_4567_89AB_CDEF shifts the full correct word.
- DIV_HALF=1, DATA_W=8, par_data=8'hC3 -> s_clk toggles every cycle, 8 edges. The bench receives 8'hC3 on latch. done comes 18 cycles after start.
